// File: rtl/usage_profile_gen_if.sv
// Handshake bundle between the usage sample source, the profile builder and
// the plan-selection consumer.
interface usage_profile_gen_if #(
  parameter int W  = 6,
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_talk;
  logic [W-1:0]  in_data;
  logic [W-1:0]  in_spend;
  logic          prof_valid;
  logic          prof_ready;
  logic [W-1:0]  avgtalk;
  logic [W-1:0]  avgdata;
  logic [W-1:0]  budjet;
  logic          window_full;
  logic [AW:0]   count;

  modport master (
    output in_valid, in_talk, in_data, in_spend, prof_ready,
    input  in_ready, prof_valid, avgtalk, avgdata, budjet, window_full, count
  );

  modport slave (
    input  in_valid, in_talk, in_data, in_spend, prof_ready,
    output in_ready, prof_valid, avgtalk, avgdata, budjet, window_full, count
  );
endinterface

// File: rtl/usage_profile_gen.sv
// Subscriber usage profile: sliding window of DEPTH billing periods producing
// rounded-up average talk/data and the peak spend for the plan selector.
module usage_profile_gen #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  usage_profile_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    win_talk  [DEPTH];
  logic [W-1:0]    win_data  [DEPTH];
  logic [W-1:0]    win_spend [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     cnt;
  logic [AW:0]     idx;
  logic [W+AW-1:0] sum_talk, sum_data;
  logic [W-1:0]    max_spend;
  logic [W-1:0]    avgtalk_r, avgdata_r, budjet_r;
  logic            accept, full;

  function automatic logic [W-1:0] ceil_avg(input logic [W+AW-1:0] s);
    return W'((s + (W+AW)'(DEPTH-1)) >> AW);
  endfunction

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign accept = (state == IDLE) && bus.in_valid && !clr;

  assign bus.in_ready    = (state == IDLE);
  assign bus.prof_valid  = (state == OUT);
  assign bus.avgtalk     = avgtalk_r;
  assign bus.avgdata     = avgdata_r;
  assign bus.budjet      = budjet_r;
  assign bus.window_full = full;
  assign bus.count       = cnt;

  // Warm-up windows return to IDLE right after the last entry is scanned;
  // a full window takes one more cycle to load the profile registers.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = SCAN;
      SCAN: begin
        if (idx == (AW+1)'(DEPTH-1) && !full) state_nx = IDLE;
        else if (idx == (AW+1)'(DEPTH))       state_nx = OUT;
      end
      OUT:  if (bus.prof_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      idx       <= '0;
      sum_talk  <= '0;
      sum_data  <= '0;
      max_spend <= '0;
      avgtalk_r <= '0;
      avgdata_r <= '0;
      budjet_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        win_talk[i]  <= '0;
        win_data[i]  <= '0;
        win_spend[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (clr) begin
        wr_ptr    <= '0;
        cnt       <= '0;
        idx       <= '0;
        sum_talk  <= '0;
        sum_data  <= '0;
        max_spend <= '0;
        avgtalk_r <= '0;
        avgdata_r <= '0;
        budjet_r  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          win_talk[i]  <= '0;
          win_data[i]  <= '0;
          win_spend[i] <= '0;
        end
      end else begin
        if (accept) begin
          win_talk[wr_ptr]  <= bus.in_talk;
          win_data[wr_ptr]  <= bus.in_data;
          win_spend[wr_ptr] <= bus.in_spend;
          wr_ptr            <= wr_ptr + 1'b1;
          sum_talk <= sum_talk + (W+AW)'(bus.in_talk)
                      - (full ? (W+AW)'(win_talk[wr_ptr]) : '0);
          sum_data <= sum_data + (W+AW)'(bus.in_data)
                      - (full ? (W+AW)'(win_data[wr_ptr]) : '0);
          if (!full) cnt <= cnt + 1'b1;
          idx       <= '0;
          max_spend <= '0;
        end
        if (state == SCAN) begin
          if (idx < (AW+1)'(DEPTH)) begin
            if (win_spend[idx[AW-1:0]] > max_spend) max_spend <= win_spend[idx[AW-1:0]];
            idx <= idx + 1'b1;
          end else begin
            avgtalk_r <= ceil_avg(sum_talk);
            avgdata_r <= ceil_avg(sum_data);
            budjet_r  <= max_spend;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usage_profile_gen.sv
// Directed bench for usage_profile_gen: warm-up, full window, eviction,
// backpressure, saturation, clr and async reset during SCAN.
module tb_usage_profile_gen;

  localparam int W = 6, DEPTH = 4, AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   pv_seen = 0;

  usage_profile_gen_if #(.W(W), .AW(AW)) bus ();

  usage_profile_gen #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.prof_valid) pv_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] t, input logic [W-1:0] d, input logic [W-1:0] s);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_ready_timeout", 32'(n), 0);
    bus.in_valid = 1'b1;
    bus.in_talk  = t;
    bus.in_data  = d;
    bus.in_spend = s;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Call right after send(): counts negedges until prof_valid is seen.
  task automatic wait_pv(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.prof_valid && lat < 30);
  endtask

  task automatic release_prof();
    @(negedge clk);
    bus.prof_ready = 1'b1;
    @(negedge clk);
    chk("release_pv", bus.prof_valid, 0);
    chk("release_rdy", bus.in_ready, 1);
    bus.prof_ready = 1'b0;
  endtask

  task automatic check_profile(input string tag, input int t, input int d, input int b);
    chk({tag, "_avgtalk"}, bus.avgtalk, t);
    chk({tag, "_avgdata"}, bus.avgdata, d);
    chk({tag, "_budjet"},  bus.budjet,  b);
    chk({tag, "_full"},    bus.window_full, 1);
    chk({tag, "_count"},   bus.count, 4);
  endtask

  task automatic fill_test1(input string tag);
    int lat;
    send(10, 5, 12);
    send(20, 5, 40);
    send(30, 5, 7);
    send(41, 5, 33);
    wait_pv(lat);
    chk({tag, "_latency"}, 32'(lat), 6);
    check_profile(tag, 26, 5, 40);
    release_prof();
  endtask

  initial begin
    int lat, pv0;
    logic [W-1:0] tv [3];
    logic [W-1:0] sv [3];
    tv[0] = 10; tv[1] = 20; tv[2] = 30;
    sv[0] = 12; sv[1] = 40; sv[2] = 7;
    bus.in_valid = 1'b0; bus.in_talk = '0; bus.in_data = '0; bus.in_spend = '0;
    bus.prof_ready = 1'b0;

    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_prof_valid", bus.prof_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_avgtalk", bus.avgtalk, 0);
    chk("rst_budjet", bus.budjet, 0);
    chk("rst_full", bus.window_full, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Warm-up: no profile, in_ready low exactly 4 cycles after each accept.
    for (int k = 0; k < 3; k++) begin
      send(tv[k], 5, sv[k]);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("warm_ready_low", bus.in_ready, 0);
      end
      @(negedge clk);
      chk("warm_ready_back", bus.in_ready, 1);
      chk("warm_count", bus.count, 32'(k + 1));
      chk("warm_full", bus.window_full, 0);
    end
    chk("warm_no_pv", 32'(pv_seen), 0);

    // Fourth sample completes the window; hold prof_ready low for backpressure.
    send(41, 5, 33);
    wait_pv(lat);
    chk("t1_latency", 32'(lat), 6);
    check_profile("t1", 26, 5, 40);
    chk("t1_in_ready", bus.in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_pv", bus.prof_valid, 1);
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_avgtalk", bus.avgtalk, 26);
      chk("bp_budjet", bus.budjet, 40);
    end
    release_prof();

    // Eviction of the oldest period.
    send(2, 9, 1);
    wait_pv(lat);
    chk("t3_latency", 32'(lat), 6);
    check_profile("t3", 24, 6, 40);
    release_prof();

    // clr in IDLE clears the profile outputs.
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_count", bus.count, 0);
    chk("clr_avgtalk", bus.avgtalk, 0);
    chk("clr_avgdata", bus.avgdata, 0);
    chk("clr_budjet", bus.budjet, 0);
    chk("clr_full", bus.window_full, 0);

    // Saturation at the top of the sample range.
    for (int k = 0; k < 3; k++) send(63, 63, 63);
    send(63, 63, 63);
    wait_pv(lat);
    chk("sat_latency", 32'(lat), 6);
    check_profile("sat", 63, 63, 63);
    release_prof();

    // clr during SCAN cycle 2 of a full window aborts the profile.
    send(1, 1, 1);
    @(negedge clk);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    pv0 = pv_seen;
    chk("clrscan_count", bus.count, 0);
    chk("clrscan_ready", bus.in_ready, 1);
    chk("clrscan_budjet", bus.budjet, 0);
    chk("clrscan_avgtalk", bus.avgtalk, 0);
    repeat (8) @(negedge clk);
    chk("clrscan_no_pv", 32'(pv_seen - pv0), 0);
    fill_test1("clrscan_refill");

    // Async reset mid-SCAN of a full window.
    send(1, 1, 1);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("arst_ready", bus.in_ready, 1);
    chk("arst_pv", bus.prof_valid, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_avgtalk", bus.avgtalk, 0);
    chk("arst_budjet", bus.budjet, 0);
    #3 rst_n = 1'b1;
    pv0 = pv_seen;
    repeat (8) @(negedge clk);
    chk("arst_no_pv", 32'(pv_seen - pv0), 0);
    fill_test1("arst_refill");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
